// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared definitions for the display controller. It holds the
//               peek FSM state type, the blank-digit pattern and the hex to
//               7-segment table. Segments are active-low, bit0 = segment a,
//               bit6 = segment g.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        ST_SHOW_REG  = 2'd0,
        ST_PEEK_HELD = 2'd1,
        ST_PEEK_HOLD = 2'd2
    } disp_state_t;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg
// Description : Combinational hex digit to active-low 7-segment decoder.
// Ports       : nib - 4-bit hex digit in
//               seg - segments out, active-low, bit0 = a
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nib);

endmodule
`default_nettype wire

// File: rtl/display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_ctrl
// Description : Drives the hex displays and LEDs of the datapath board. The
//               data digits normally show REG; pressing PEEK shows a snapshot
//               of BUS, held for PEEK_HOLD cycles after release. The HEX5
//               decimal point blinks while DONE is high.
// Ports       : CLK    - clock, rising edge
//               RST    - synchronous active-high reset
//               BUS    - data bus value
//               REG    - register Q1 value
//               TIME   - current timestep
//               DONE   - operation-complete level
//               PEEKb  - peek pushbutton, active-low, asynchronous
//               BLANKZ - blank leading-zero digits when high
//               LED_B  - BUS delayed by one cycle
//               DHEX   - data digits, [0] least significant, active-low
//               THEX   - timestep digit, active-low
//               LED_D  - blinking DONE dot, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module display_ctrl
    import display_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int NUM_DIG    = 3,
    parameter int TIME_W     = 2,
    parameter int PEEK_HOLD  = 50_000_000,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] BUS,
    input  logic [DATA_W-1:0] REG,
    input  logic [TIME_W-1:0] TIME,
    input  logic              DONE,
    input  logic              PEEKb,
    input  logic              BLANKZ,
    output logic [DATA_W-1:0] LED_B,
    output logic [6:0]        DHEX [NUM_DIG-1:0],
    output logic [6:0]        THEX,
    output logic              LED_D
);

    localparam int EXT_W   = 4 * NUM_DIG;
    localparam int HOLD_W  = (PEEK_HOLD  > 1) ? $clog2(PEEK_HOLD)  : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(PEEK_HOLD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    // ------------------------------------------------------------------
    // Button synchronizer; flops idle high (button released)
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_peek_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= PEEKb;
            r_sync2 <= r_sync1;
        end
    end

    assign w_peek_s = ~r_sync2;

    // ------------------------------------------------------------------
    // Peek FSM
    // ------------------------------------------------------------------
    disp_state_t       r_state;
    disp_state_t       w_state_next;
    logic              w_capture;
    logic              w_hold_load;
    logic              w_hold_dec;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [DATA_W-1:0] r_peek_val;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_SHOW_REG;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_hold_load  = 1'b0;
        w_hold_dec   = 1'b0;
        case (r_state)
            ST_SHOW_REG: begin
                if (w_peek_s) begin
                    w_state_next = ST_PEEK_HELD;
                    w_capture    = 1'b1;
                end
            end
            ST_PEEK_HELD: begin
                if (!w_peek_s) begin
                    w_state_next = ST_PEEK_HOLD;
                    w_hold_load  = 1'b1;
                end
            end
            ST_PEEK_HOLD: begin
                // A new press wins over the running hold and takes a fresh snapshot
                if (w_peek_s) begin
                    w_state_next = ST_PEEK_HELD;
                    w_capture    = 1'b1;
                end else if (r_hold_cnt == '0) begin
                    w_state_next = ST_SHOW_REG;
                end else begin
                    w_hold_dec   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SHOW_REG;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_cnt <= '0;
        end else if (w_hold_load) begin
            r_hold_cnt <= HOLD_LOAD;
        end else if (w_hold_dec) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end else if (w_capture) begin
            r_hold_cnt <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_peek_val <= '0;
        end else if (w_capture) begin
            r_peek_val <= BUS;
        end
    end

    // ------------------------------------------------------------------
    // Digit formation, decode and leading-zero blanking
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  w_disp;
    logic [EXT_W-1:0]   w_ext;
    logic [3:0]         w_nib [NUM_DIG:0];
    logic [6:0]         w_seg [NUM_DIG:0];
    logic [NUM_DIG-1:0] w_blank;

    assign w_disp = (r_state == ST_SHOW_REG) ? REG : r_peek_val;
    assign w_ext  = EXT_W'(w_disp);

    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_nib
        assign w_nib[gi] = w_ext[4*gi +: 4];
    end
    // The extra decoder slot carries the timestep digit
    assign w_nib[NUM_DIG] = 4'(TIME);

    for (genvar gi = 0; gi <= NUM_DIG; gi++) begin : g_dec
        seven_seg u_seven_seg (
            .nib (w_nib[gi]),
            .seg (w_seg[gi])
        );
    end

    // Walk from the most significant digit down; a digit is blank while it
    // and every digit above it are zero. Digit 0 always stays visible.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        w_blank  = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            run_zero   = run_zero & (w_nib[i] == 4'h0);
            w_blank[i] = BLANKZ & run_zero & (i != 0);
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            LED_B <= '0;
            THEX  <= SEG_TABLE[0];
            for (int i = 0; i < NUM_DIG; i++) begin
                DHEX[i] <= SEG_TABLE[0];
            end
        end else begin
            LED_B <= BUS;
            THEX  <= w_seg[NUM_DIG];
            for (int i = 0; i < NUM_DIG; i++) begin
                DHEX[i] <= w_blank[i] ? SEG_BLANK : w_seg[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // DONE dot blink: lit immediately on a DONE rise, then toggles every
    // BLINK_HALF cycles; dark and counter parked while DONE is low.
    // ------------------------------------------------------------------
    logic               r_done_prev;
    logic [BLINK_W-1:0] r_blink_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_done_prev <= 1'b0;
            r_blink_cnt <= '0;
            LED_D       <= 1'b1;
        end else begin
            r_done_prev <= DONE;
            if (!DONE) begin
                r_blink_cnt <= '0;
                LED_D       <= 1'b1;
            end else if (!r_done_prev) begin
                r_blink_cnt <= '0;
                LED_D       <= 1'b0;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                LED_D       <= ~LED_D;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_ctrl
// Description : Self-checking bench for display_ctrl. A timestamp-based
//               reference model predicts every output each cycle; directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_ctrl;

    localparam int DW = 10;
    localparam int ND = 3;
    localparam int TW = 2;
    localparam int PH = 8;
    localparam int BH = 4;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] BUS;
    logic [DW-1:0] REG;
    logic [TW-1:0] TIME;
    logic          DONE;
    logic          PEEKb;
    logic          BLANKZ;
    logic [DW-1:0] LED_B;
    logic [6:0]    DHEX [ND-1:0];
    logic [6:0]    THEX;
    logic          LED_D;

    int checks = 0;
    int errors = 0;

    display_ctrl #(
        .DATA_W     (DW),
        .NUM_DIG    (ND),
        .TIME_W     (TW),
        .PEEK_HOLD  (PH),
        .BLINK_HALF (BH)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BUS    (BUS),
        .REG    (REG),
        .TIME   (TIME),
        .DONE   (DONE),
        .PEEKb  (PEEKb),
        .BLANKZ (BLANKZ),
        .LED_B  (LED_B),
        .DHEX   (DHEX),
        .THEX   (THEX),
        .LED_D  (LED_D)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] r;
        case (d)
            0:  r = 7'h40;  1:  r = 7'h79;  2:  r = 7'h24;  3:  r = 7'h30;
            4:  r = 7'h19;  5:  r = 7'h12;  6:  r = 7'h02;  7:  r = 7'h78;
            8:  r = 7'h00;  9:  r = 7'h10;  10: r = 7'h08;  11: r = 7'h03;
            12: r = 7'h46;  13: r = 7'h21;  14: r = 7'h06;  15: r = 7'h0E;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    // Packed {DHEX[2],DHEX[1],DHEX[0]}: a digit blanks when nothing is left
    // of the value at or above its position.
    function automatic logic [20:0] enc(input logic [DW-1:0] v, input logic bz);
        logic [20:0] r;
        int vi;
        vi = int'(v);
        for (int i = 0; i < ND; i++) begin
            if (bz && i > 0 && (vi >> (4 * i)) == 0) r[7*i +: 7] = 7'h7F;
            else                                     r[7*i +: 7] = seg_of((vi >> (4 * i)) % 16);
        end
        return r;
    endfunction

    function automatic logic [20:0] dhex_now();
        return {DHEX[2], DHEX[1], DHEX[0]};
    endfunction

    // ------------------------------------------------------------------
    // Reference model and per-cycle compare
    // ------------------------------------------------------------------
    logic          m_valid = 1'b0;
    logic [DW-1:0] e_led_b;
    logic [20:0]   e_dhex;
    logic [6:0]    e_thex;
    logic          e_led_d;
    int            m_run;
    logic          m_h1, m_h2, m_ps;
    logic          m_in_press, m_rel_valid, m_show_peek;
    int            m_edge, m_rel_edge;
    logic [DW-1:0] m_peek_val;

    always @(posedge CLK) begin
        if (RST) begin
            m_valid     = 1'b1;
            e_led_b     = '0;
            e_dhex      = {3{7'h40}};
            e_thex      = 7'h40;
            e_led_d     = 1'b1;
            m_run       = 0;
            m_h1        = 1'b1;
            m_h2        = 1'b1;
            m_in_press  = 1'b0;
            m_rel_valid = 1'b0;
            m_show_peek = 1'b0;
            m_peek_val  = '0;
            m_edge      = 0;
            m_rel_edge  = 0;
        end else if (m_valid) begin
            m_edge++;
            e_led_b = BUS;
            e_thex  = seg_of(int'(TIME));
            e_dhex  = enc(m_show_peek ? m_peek_val : REG, BLANKZ);
            m_run   = DONE ? m_run + 1 : 0;
            e_led_d = (m_run == 0) ? 1'b1 : ((((m_run - 1) / BH) % 2) == 1 ? 1'b1 : 1'b0);
            // the button is seen two edges after it is sampled
            m_ps = !m_h2;
            m_h2 = m_h1;
            m_h1 = PEEKb;
            if (m_ps && !m_in_press) m_peek_val = BUS;
            if (!m_ps && m_in_press) begin
                m_rel_edge  = m_edge;
                m_rel_valid = 1'b1;
            end
            m_in_press  = m_ps;
            m_show_peek = m_in_press || (m_rel_valid && (m_edge - m_rel_edge) < PH);
        end
        #1;
        if (m_valid) begin
            chk("model_led_b", 32'(LED_B), 32'(e_led_b));
            chk("model_dhex",  32'(dhex_now()), 32'(e_dhex));
            chk("model_thex",  32'(THEX), 32'(e_thex));
            chk("model_led_d", 32'(LED_D), 32'(e_led_d));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    localparam logic [20:0] D_2A5 = {7'h24, 7'h08, 7'h12};
    localparam logic [20:0] D_1F0 = {7'h79, 7'h0E, 7'h40};
    localparam logic [20:0] D_077 = {7'h40, 7'h78, 7'h78};
    localparam logic [20:0] D_000 = {7'h40, 7'h40, 7'h40};

    initial begin
        logic [11:0] pat;
        pat    = 12'b0000_1111_0000;
        RST    = 1'b1;
        BUS    = '0;
        REG    = '0;
        TIME   = '0;
        DONE   = 1'b0;
        PEEKb  = 1'b1;
        BLANKZ = 1'b0;
        tick(2);
        chk("rst_led_b", 32'(LED_B), 32'h0);
        chk("rst_dhex",  32'(dhex_now()), 32'(D_000));
        chk("rst_thex",  32'(THEX), 32'h40);
        chk("rst_led_d", 32'(LED_D), 32'h1);

        // Plain register display
        RST  = 1'b0;
        REG  = 10'h2A5;
        BUS  = 10'h123;
        TIME = 2'd2;
        tick(2);
        chk("show_2A5",   32'(dhex_now()), 32'(D_2A5));
        chk("led_b_lag",  32'(LED_B), 32'h123);
        chk("thex_2",     32'(THEX), 32'h24);
        BUS = 10'h0C3;
        tick(1);
        chk("led_b_next", 32'(LED_B), 32'h0C3);

        // Peek: visible on the 4th edge after press, held after release
        BUS   = 10'h1F0;
        TIME  = 2'd3;
        PEEKb = 1'b0;
        tick(3);
        chk("peek_not_yet", 32'(dhex_now()), 32'(D_2A5));
        tick(1);
        chk("peek_1F0", 32'(dhex_now()), 32'(D_1F0));
        tick(1);
        PEEKb = 1'b1;
        BUS   = 10'h003;
        tick(11);
        chk("hold_last", 32'(dhex_now()), 32'(D_1F0));
        tick(1);
        chk("hold_expired", 32'(dhex_now()), 32'(D_2A5));

        // Re-press during the hold
        BUS   = 10'h100;
        PEEKb = 1'b0;
        tick(6);
        PEEKb = 1'b1;
        tick(6);
        BUS   = 10'h077;
        PEEKb = 1'b0;
        tick(4);
        chk("repress_077", 32'(dhex_now()), 32'(D_077));
        BUS   = 10'h3FF;
        PEEKb = 1'b1;
        tick(11);
        chk("rehold_last", 32'(dhex_now()), 32'(D_077));
        tick(1);
        chk("rehold_expired", 32'(dhex_now()), 32'(D_2A5));

        // Leading-zero blanking
        BLANKZ = 1'b1;
        REG    = 10'h005;
        TIME   = 2'd1;
        tick(2);
        chk("blank_005", 32'(dhex_now()), 32'({7'h7F, 7'h7F, 7'h12}));
        REG = 10'h000;
        tick(2);
        chk("blank_000", 32'(dhex_now()), 32'({7'h7F, 7'h7F, 7'h40}));
        REG = 10'h050;
        tick(2);
        chk("blank_050", 32'(dhex_now()), 32'({7'h7F, 7'h12, 7'h40}));
        BLANKZ = 1'b0;
        REG    = 10'h005;
        tick(2);
        chk("noblank_005", 32'(dhex_now()), 32'({7'h40, 7'h40, 7'h12}));

        // DONE blink
        REG  = 10'h2A5;
        DONE = 1'b1;
        for (int k = 0; k < 12; k++) begin
            TIME = TW'(k);
            tick(1);
            chk("blink", 32'(LED_D), 32'(pat[k]));
        end
        DONE = 1'b0;
        tick(1);
        chk("done_fall", 32'(LED_D), 32'h1);

        // Reset in the middle of a hold with DONE high
        DONE  = 1'b1;
        BUS   = 10'h155;
        PEEKb = 1'b0;
        tick(6);
        PEEKb = 1'b1;
        tick(7);
        RST = 1'b1;
        tick(1);
        chk("mid_rst_led_b", 32'(LED_B), 32'h0);
        chk("mid_rst_dhex",  32'(dhex_now()), 32'(D_000));
        chk("mid_rst_thex",  32'(THEX), 32'h40);
        chk("mid_rst_led_d", 32'(LED_D), 32'h1);
        RST = 1'b0;
        BUS = 10'h2AA;
        tick(2);
        chk("post_rst_show_reg", 32'(dhex_now()), 32'(D_2A5));
        chk("post_rst_blink",    32'(LED_D), 32'h0);
        tick(12);
        chk("post_rst_no_hold",  32'(dhex_now()), 32'(D_2A5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
